// File: rtl/dds_sweep_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dds_sweep_sequencer_if                                          |
// | Purpose  : Control/status bundle between the sweep controls and the        |
// |            DDS sweep sequencer.                                            |
// | Signals  : start, stop, continuous, f_start, f_stop, f_inc, dwell          |
// |            (controller -> sequencer)                                       |
// |            freq, freq_load, busy, done, sweep_cnt (sequencer -> controller)|
// | Modports : master = controller side, slave = sequencer side               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface dds_sweep_sequencer_if #(
   parameter int FW = 6,
   parameter int DW = 16
);
   logic          start;
   logic          stop;
   logic          continuous;
   logic [FW-1:0] f_start;
   logic [FW-1:0] f_stop;
   logic [FW-1:0] f_inc;
   logic [DW-1:0] dwell;
   logic [FW-1:0] freq;
   logic          freq_load;
   logic          busy;
   logic          done;
   logic [7:0]    sweep_cnt;

   modport master (
      output start, stop, continuous, f_start, f_stop, f_inc, dwell,
      input  freq, freq_load, busy, done, sweep_cnt
   );

   modport slave (
      input  start, stop, continuous, f_start, f_stop, f_inc, dwell,
      output freq, freq_load, busy, done, sweep_cnt
   );
endinterface
`default_nettype wire

// File: rtl/dds_sweep_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dds_sweep_sequencer                                             |
// | Purpose  : Frequency-sweep scheduler for the DDS phase-accumulator path.   |
// |            Latches start/stop/increment/dwell on start, then steps the     |
// |            frequency word from start to stop, holding each word for        |
// |            max(dwell,1)+1 clocks. Reports busy, done and pass count.       |
// | Ports    : clk   - system clock                                            |
// |            rst   - asynchronous active-high reset                          |
// |            sweep - dds_sweep_sequencer_if.slave (controls in, status out)  |
// | Options  : SWEEP_BIDIR_EN - when defined, continuous mode turns around at  |
// |            each endpoint (triangle sweep) instead of reloading the start   |
// |            word (saw-tooth sweep).                                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dds_sweep_sequencer #(
   parameter int FW = 6,
   parameter int DW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   dds_sweep_sequencer_if.slave sweep
);

   localparam logic [2:0]    c_IDLE   = 3'd0;
   localparam logic [2:0]    c_LOAD   = 3'd1;
   localparam logic [2:0]    c_DWELL  = 3'd2;
   localparam logic [2:0]    c_STEP   = 3'd3;
   localparam logic [2:0]    c_FINISH = 3'd4;

   localparam logic [FW-1:0] c_FW_ONE = {{(FW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0] c_DW_ONE = {{(DW-1){1'b0}}, 1'b1};

   // FSM state
   logic [2:0]    state_q, state_d;

   // Latched sweep configuration
   logic [FW-1:0] cfg_start_q, cfg_start_d;
   logic [FW-1:0] cfg_stop_q,  cfg_stop_d;
   logic [FW-1:0] cfg_inc_q,   cfg_inc_d;
   logic [DW-1:0] cfg_dwell_q, cfg_dwell_d;
   logic          cfg_cont_q,  cfg_cont_d;

   // Dwell counter and registered outputs
   logic [DW-1:0] cnt_q,       cnt_d;
   logic [FW-1:0] freq_q,      freq_d;
   logic          freq_load_q, freq_load_d;
   logic          busy_q,      busy_d;
   logic          done_q,      done_d;
   logic [7:0]    sweep_cnt_q, sweep_cnt_d;

   // Combinational helpers
   logic          w_start_req;
   logic          w_abort;
   logic          w_at_stop;
   logic          w_up;
   logic          w_turn;
   logic [FW:0]   w_sum;
   logic [FW:0]   w_diff;
   logic [FW-1:0] w_next_freq;

   // stop takes priority over start, so a simultaneous pair never launches
   assign w_start_req = sweep.start && !sweep.stop;
   assign w_abort     = sweep.stop && (state_q != c_IDLE);
   assign w_at_stop   = (freq_q == cfg_stop_q);
   assign w_up        = (cfg_start_q <= cfg_stop_q);

   // One extra bit so overflow past the top / borrow below zero is visible
   // and the clamp to the stop word can never be fooled by a wrap.
   assign w_sum  = {1'b0, freq_q} + {1'b0, cfg_inc_q};
   assign w_diff = {1'b0, freq_q} - {1'b0, cfg_inc_q};

   always_comb begin
      w_next_freq = cfg_stop_q;
      if (w_up) begin
         if (w_sum <= {1'b0, cfg_stop_q}) begin
            w_next_freq = w_sum[FW-1:0];
         end
      end else begin
         if (!w_diff[FW] && (w_diff[FW-1:0] >= cfg_stop_q)) begin
            w_next_freq = w_diff[FW-1:0];
         end
      end
   end

   // End-of-pass turn-around in continuous mode (triangle sweep option)
`ifdef SWEEP_BIDIR_EN
   assign w_turn = cfg_cont_q;
`else
   assign w_turn = 1'b0;
`endif

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= c_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE: begin
            if (w_start_req) begin
               state_d = c_LOAD;
            end
         end
         c_LOAD: begin
            state_d = c_DWELL;
         end
         c_DWELL: begin
            if (cnt_q == '0) begin
               state_d = c_STEP;
            end
         end
         c_STEP: begin
            if (w_at_stop) begin
               if (!cfg_cont_q) begin
                  state_d = c_FINISH;
               end else if (w_turn) begin
                  state_d = c_DWELL;
               end else begin
                  state_d = c_LOAD;
               end
            end else begin
               state_d = c_DWELL;
            end
         end
         c_FINISH: begin
            state_d = c_IDLE;
         end
         default: begin
            state_d = c_IDLE;
         end
      endcase
      if (w_abort) begin
         state_d = c_IDLE;
      end
   end

   // ------------------------------------------------------------------
   // Output / datapath logic. Each state's action lands in the output
   // registers on the edge that leaves the state, so freq/freq_load/
   // busy/done appear one clock after the state that produces them.
   // ------------------------------------------------------------------
   always_comb begin
      cfg_start_d = cfg_start_q;
      cfg_stop_d  = cfg_stop_q;
      cfg_inc_d   = cfg_inc_q;
      cfg_dwell_d = cfg_dwell_q;
      cfg_cont_d  = cfg_cont_q;
      cnt_d       = cnt_q;
      freq_d      = freq_q;
      freq_load_d = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      sweep_cnt_d = sweep_cnt_q;

      case (state_q)
         c_IDLE: begin
            busy_d = 1'b0;
            if (w_start_req) begin
               cfg_start_d = sweep.f_start;
               cfg_stop_d  = sweep.f_stop;
               cfg_inc_d   = (sweep.f_inc == '0) ? c_FW_ONE : sweep.f_inc;
               cfg_dwell_d = (sweep.dwell == '0) ? c_DW_ONE : sweep.dwell;
               cfg_cont_d  = sweep.continuous;
               sweep_cnt_d = 8'd0;
            end
         end
         c_LOAD: begin
            freq_d      = cfg_start_q;
            freq_load_d = 1'b1;
            busy_d      = 1'b1;
            cnt_d       = cfg_dwell_q - c_DW_ONE;
         end
         c_DWELL: begin
            busy_d = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - c_DW_ONE;
            end
         end
         c_STEP: begin
            busy_d = 1'b1;
            if (w_at_stop) begin
               sweep_cnt_d = sweep_cnt_q + 8'd1;
               if (cfg_cont_q && w_turn) begin
                  // Endpoint is re-held for another dwell without a load
                  // strobe; swapping the words reverses the direction.
                  cfg_start_d = cfg_stop_q;
                  cfg_stop_d  = cfg_start_q;
                  cnt_d       = cfg_dwell_q - c_DW_ONE;
               end
            end else begin
               freq_d      = w_next_freq;
               freq_load_d = 1'b1;
               cnt_d       = cfg_dwell_q - c_DW_ONE;
            end
         end
         c_FINISH: begin
            done_d = 1'b1;
            busy_d = 1'b0;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase

      // An abort cancels the current state's action entirely; busy then
      // drops one clock later when IDLE is processed.
      if (w_abort) begin
         cfg_start_d = cfg_start_q;
         cfg_stop_d  = cfg_stop_q;
         cnt_d       = cnt_q;
         freq_d      = freq_q;
         freq_load_d = 1'b0;
         busy_d      = busy_q;
         done_d      = 1'b0;
         sweep_cnt_d = sweep_cnt_q;
      end
   end

   // ------------------------------------------------------------------
   // Datapath and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_start_q <= '0;
         cfg_stop_q  <= '0;
         cfg_inc_q   <= '0;
         cfg_dwell_q <= '0;
         cfg_cont_q  <= 1'b0;
         cnt_q       <= '0;
         freq_q      <= '0;
         freq_load_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sweep_cnt_q <= 8'd0;
      end else begin
         cfg_start_q <= cfg_start_d;
         cfg_stop_q  <= cfg_stop_d;
         cfg_inc_q   <= cfg_inc_d;
         cfg_dwell_q <= cfg_dwell_d;
         cfg_cont_q  <= cfg_cont_d;
         cnt_q       <= cnt_d;
         freq_q      <= freq_d;
         freq_load_q <= freq_load_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sweep_cnt_q <= sweep_cnt_d;
      end
   end

   assign sweep.freq      = freq_q;
   assign sweep.freq_load = freq_load_q;
   assign sweep.busy      = busy_q;
   assign sweep.done      = done_q;
   assign sweep.sweep_cnt = sweep_cnt_q;

endmodule
`default_nettype wire

// File: doc/dds_sweep_sequencer.md
# dds_sweep_sequencer

Frequency-sweep scheduler for the DDS waveform generator. It sits between the user controls and the phase-accumulator datapath. Once per sweep it latches a start word, stop word, increment and dwell time, then steps the datapath's per-clock address increment (the 6-bit frequency word) from start to stop. Each frequency is held for a programmed number of clocks, and the block reports progress and completion.

## Interface
Parameters:
- `FW`, default 6: frequency word width, matching the datapath's 6-bit address increment.
- `DW`, default 16: dwell counter width.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle request to begin a sweep.
- `stop` in 1: one-cycle request to abort a sweep.
- `continuous` in 1: 1 repeats sweeps until `stop`; 0 runs a single sweep. Sampled at `start`.
- `f_start` in FW: first frequency word.
- `f_stop` in FW: last frequency word.
- `f_inc` in FW: step size. 0 is treated as 1.
- `dwell` in DW: clocks per frequency. 0 is treated as 1.
- `freq` out FW: frequency word driven to the datapath.
- `freq_load` out 1: one-cycle strobe in the cycle `freq` takes a new value.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse when a single sweep completes.
- `sweep_cnt` out 8: completed sweep passes since the last `start`. Wraps 255→0.

## Operation
- States:
  - IDLE: wait for `start`.
  - LOAD: drive the first word.
  - DWELL: count `dwell` clocks.
  - STEP: compute the next word.
  - FINISH: pulse `done`.
- Reset value of all outputs is 0. State is IDLE and all latched configuration is 0.
- IDLE, `start`=1 and `stop`=0: latch `f_start`, `f_stop`, `f_inc`, `dwell` and `continuous`; clear `sweep_cnt`; go to LOAD.
- Direction:
  - Up when latched `f_start` ≤ `f_stop`, down otherwise.
  - `f_start` == `f_stop` is a single-point sweep.
- LOAD: `freq` ← start word, `freq_load`=1, `busy`=1. Go to DWELL with the dwell counter set to dwell−1.
- DWELL: decrement the counter. At 0, go to STEP.
- STEP:
  - If `freq` == stop word, the pass is complete and `sweep_cnt` increments:
    - Single mode: go to FINISH.
    - Continuous mode: go to LOAD, unless `SWEEP_BIDIR_EN` applies (see Configuration).
  - Otherwise `freq` ← `freq` ± inc, clamped so it never passes the stop word. Clamp detection uses an FW+1-bit intermediate, so the result never wraps. Assert `freq_load` and go to DWELL.
- FINISH: `done`=1 and `busy`=0 in this cycle. Go to IDLE. `freq` holds the stop word.
- `stop` in any non-IDLE state returns to IDLE on the next edge.
  - `freq` holds its current value and `busy` drops.
  - No `done` pulse. `sweep_cnt` holds.
- `start` and `stop` in the same cycle: `stop` wins, and `start` is ignored.
- `start` while `busy`: ignored. Changes to config inputs during a sweep have no effect.
- `rst` asserted mid-sweep: immediate return to reset values, with no `done` pulse.

## Timing
- `start` sampled high at edge N gives `freq`=`f_start`, `freq_load`=1 and `busy`=1 after edge N+1.
- Each frequency is held for exactly max(`dwell`,1)+1 clocks: `dwell` clocks in DWELL plus 1 clock in STEP. `freq_load` pulses are that many clocks apart.
- The final word is held its full dwell, then STEP, then FINISH. `done` appears 1 clock after STEP.
- In continuous restart, LOAD adds 1 clock. The start word follows the stop word after dwell+2 clocks.
- `stop` at edge M gives `busy`=0 after edge M+1.

## Configuration
- `SWEEP_BIDIR_EN` defined:
  - In continuous mode, at the end of a pass, swap the start and stop words and reverse direction. `freq` then steps back from the stop word without re-entering LOAD, giving a triangle sweep.
  - Each reversal counts as one pass.
  - The turn-around STEP re-emits the endpoint with no `freq_load`, so the endpoint is held for 2×(dwell+1) clocks.
- Undefined: continuous mode always re-enters LOAD and saw-tooth sweeps from the original start word.
- Single-mode behaviour is identical either way.

## Test plan
- Reset: assert `rst` mid-DWELL → all outputs 0 immediately. Deassert, then `start` → sweep runs normally from LOAD.
- Single up sweep, `f_start`=1, `f_stop`=5, `f_inc`=2, `dwell`=3:
  - `freq` goes 1, 3, 5, each for 4 clocks, with 3 `freq_load` pulses.
  - `done` comes 13 clocks after the first `freq_load`, then `sweep_cnt`=1 and `busy`=0.
- Clamp and down sweep, `f_start`=50, `f_stop`=40, `f_inc`=4, `dwell`=0:
  - `freq` goes 50, 46, 42, 40, each for 2 clocks, followed by `done`.
  - `f_inc`=0 gives 50, 49, …, 40.
- Continuous, `f_start`=1, `f_stop`=3, `f_inc`=1:
  - Without the macro: 1, 2, 3, 1, 2, 3 and `sweep_cnt` increments per pass.
  - With `SWEEP_BIDIR_EN`: 1, 2, 3, 3, 2, 1, 1, 2, …
- Abort: `stop` during the word-3 dwell → `busy`=0 next clock, `freq` stays 3, no `done`. Also `start` during the sweep is ignored, and `start`+`stop` together in IDLE leave `busy`=0.
- Single point, `f_start`=`f_stop`=7 → one `freq_load` with `freq`=7, then `done` after dwell+2 clocks.
